// File: rtl/vend_ctrl_if.sv
// Host-side bus of the vending controller: coin/purchase/cancel requests in,
// credit, dispense and change events out.
interface vend_ctrl_if;
    logic        coin_valid;
    logic [1:0]  coin_sel;
    logic        item_req;
    logic        item_sel;
    logic        cancel;
    logic [2:0]  state;
    logic [15:0] money_out;
    logic        vend;
    logic        change_valid;
    logic [15:0] change_amt;
    logic        coin_rej;
    logic        busy;

    modport master (
        output coin_valid, coin_sel, item_req, item_sel, cancel,
        input  state, money_out, vend, change_valid, change_amt, coin_rej, busy
    );

    modport slave (
        input  coin_valid, coin_sel, item_req, item_sel, cancel,
        output state, money_out, vend, change_valid, change_amt, coin_rej, busy
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending controller: BCD credit accumulation, price check, dispense, change and idle refund.
// Define VEND_CANCEL_EN to let the cancel input refund the credit from COLLECT.
//
// state   | meaning
// IDLE    | no credit, waiting for the first coin
// COLLECT | accepting coins, waiting for a purchase request or idle timeout
// CHECK   | comparing credit against the latched price
// VEND    | dispense pulse, credit already reduced by the price
// CHANGE  | change/refund pulse, credit cleared on exit
module vend_ctrl #(
    parameter logic [15:0] PRICE_A = 16'h0125,
    parameter logic [15:0] PRICE_B = 16'h0200,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    vend_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_COLLECT = 3'b001,
        S_CHECK   = 3'b010,
        S_VEND    = 3'b011,
        S_CHANGE  = 3'b100
    } state_t;

    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] credit_q;
    logic [15:0] price_q;
    logic [15:0] timer_q;
    logic [15:0] change_amt_q;
    logic        vend_q;
    logic        change_valid_q;
    logic        coin_rej_q;

    logic [15:0] coin_val_d;
    logic [15:0] add_sum_d;
    logic        add_ovf_d;
    logic        accept_d;
    logic        coin_rej_d;
    logic [15:0] credit_add_d;

    // Returns {decimal carry out, 4-digit BCD sum}.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  d;
        logic        c;
        logic [15:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
            if (d > 5'd9) begin
                d = d + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[i*4 +: 4] = d[3:0];
        end
        return {c, s};
    endfunction

    // Only called with a >= b, so the final borrow is always zero.
    function automatic logic [15:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  d;
        logic        br;
        logic [15:0] s;
        br = 1'b0;
        s  = '0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, br};
            if (d[4]) begin
                d  = d + 5'd10;
                br = 1'b1;
            end else begin
                br = 1'b0;
            end
            s[i*4 +: 4] = d[3:0];
        end
        return s;
    endfunction

    always_comb begin
        case (bus.coin_sel)
            2'b00:   coin_val_d = 16'h0005;
            2'b01:   coin_val_d = 16'h0010;
            2'b10:   coin_val_d = 16'h0025;
            default: coin_val_d = 16'h0100;
        endcase
        {add_ovf_d, add_sum_d} = bcd_add(credit_q, coin_val_d);
        accept_d     = (state_q == S_IDLE) || (state_q == S_COLLECT);
        coin_rej_d   = 1'b0;
        credit_add_d = credit_q;
        if (bus.coin_valid) begin
            if (!accept_d || add_ovf_d) begin
                coin_rej_d = 1'b1;
            end else begin
                credit_add_d = add_sum_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            price_q        <= '0;
            timer_q        <= '0;
            change_amt_q   <= '0;
            vend_q         <= 1'b0;
            change_valid_q <= 1'b0;
            coin_rej_q     <= 1'b0;
        end else begin
            vend_q         <= 1'b0;
            change_valid_q <= 1'b0;
            coin_rej_q     <= coin_rej_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.coin_valid && !coin_rej_d) begin
                        credit_q <= credit_add_d;
                        timer_q  <= TIMER_LOAD;
                        state_q  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    credit_q <= credit_add_d;
`ifdef VEND_CANCEL_EN
                    if (bus.cancel) begin
                        change_amt_q   <= credit_add_d;
                        change_valid_q <= 1'b1;
                        state_q        <= S_CHANGE;
                    end else
`endif
                    if (bus.item_req) begin
                        price_q <= bus.item_sel ? PRICE_B : PRICE_A;
                        timer_q <= TIMER_LOAD;
                        state_q <= S_CHECK;
                    end else if (bus.coin_valid) begin
                        timer_q <= TIMER_LOAD;
                    end else if (timer_q == '0) begin
                        change_amt_q   <= credit_add_d;
                        change_valid_q <= 1'b1;
                        state_q        <= S_CHANGE;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_CHECK: begin
                    // Packed BCD orders the same as binary, so a plain compare suffices.
                    if (credit_q >= price_q) begin
                        credit_q <= bcd_sub(credit_q, price_q);
                        vend_q   <= 1'b1;
                        state_q  <= S_VEND;
                    end else begin
                        timer_q <= TIMER_LOAD;
                        state_q <= S_COLLECT;
                    end
                end
                S_VEND: begin
                    if (credit_q != '0) begin
                        change_amt_q   <= credit_q;
                        change_valid_q <= 1'b1;
                        state_q        <= S_CHANGE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHANGE: begin
                    credit_q <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifndef VEND_CANCEL_EN
    logic unused_cancel;
    assign unused_cancel = bus.cancel;
`endif

    assign bus.state        = state_q;
    assign bus.money_out    = credit_q;
    assign bus.vend         = vend_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.coin_rej     = coin_rej_q;
    assign bus.busy         = (state_q == S_CHECK) || (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule
